reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file with write-to-read bypass, a per-register busy scoreboard, and a hardware clear sequencer. It is the next-generation integer register file for the pipeline decode/writeback stages. Decode reads operands and reserves destinations; writeback writes results and releases them. After reset, or on request, the block zeroes the whole array itself.

## Interface
- REG_DATA_WIDTH, 32, register width in bits
- REG_SEL_BITS, 5, select width; DEPTH = 1<<REG_SEL_BITS registers
- NUM_READ_PORTS, 2, number of independent combinational read ports (≥1)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = no forwarding

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- init_req  in  1  request a full array clear; sampled in RUN only
- ready  out  1  high when in RUN; low while clearing
- wEn  in  1  write enable
- write_sel  in  REG_SEL_BITS  write address
- write_data  in  REG_DATA_WIDTH  write data
- read_sel  in  NUM_READ_PORTS*REG_SEL_BITS  packed read addresses; port i = bits [i*REG_SEL_BITS +: REG_SEL_BITS]
- read_data  out  NUM_READ_PORTS*REG_DATA_WIDTH  packed read data, same packing
- rsv_en  in  1  reserve (mark busy) a destination register
- rsv_sel  in  REG_SEL_BITS  register to reserve
- read_busy  out  NUM_READ_PORTS  per-port busy flag for the selected register

## Operation
- FSM has two states: CLEAR and RUN.
- While reset is low, the block is held as follows:
  - state = CLEAR, clear index = 0, all busy bits = 0, ready = 0.
- CLEAR behaviour:
  - Each cycle, register[index] is written to 0 and index increments.
  - The cycle that writes index DEPTH-1 moves the FSM to RUN.
  - wEn, rsv_en and init_req are ignored.
  - All read_data = 0 and all read_busy = 0.
- RUN behaviour:
  - init_req = 1 moves the FSM to CLEAR at the next edge.
  - On that edge, index resets to 0 and all busy bits clear.
  - The write on that edge (if any) is dropped.
- Write: at a rising edge with wEn = 1 and write_sel != 0, register[write_sel] <= write_data. Writes to 0 are discarded.
- Read port i (combinational):
  - read_sel_i == 0 → 0.
  - BYPASS = 1, wEn = 1 and write_sel == read_sel_i → write_data.
  - Otherwise → register[read_sel_i].
- Scoreboard (DEPTH busy bits; busy[0] is constant 0):
  - rsv_en = 1 with rsv_sel != 0 sets busy[rsv_sel].
  - wEn = 1 with write_sel != 0 clears busy[write_sel].
  - Same register reserved and written in one cycle → the register stays busy (the new producer wins). The data is still written.
  - Reserving an already-busy register leaves it busy; there is no counting.
- read_busy_i = busy[read_sel_i], except it is forced to 0 when BYPASS = 1 and a write to that register is in progress this cycle (the forwarded value is final).

## Timing
- Read latency is 0 cycles (combinational from read_sel, the array, and the write-bypass inputs).
- A write is visible on non-bypassed reads from the cycle after the edge; with BYPASS = 1 it is visible in the same cycle.
- A busy bit set or cleared at edge N is reflected in read_busy from cycle N onward (after the edge).
- Clear takes exactly DEPTH cycles. ready rises after the DEPTH-th rising edge following reset deassertion (or following the edge that accepted init_req).
- Reset values: ready = 0, read_data = 0, read_busy = 0. The array contents are undefined until the sweep completes; outputs mask them.
- Reset asserted mid-sweep or mid-RUN: the FSM returns to CLEAR with index 0 immediately and asynchronously; the sweep restarts from scratch.
- Index wrap: index is REG_SEL_BITS wide. The transition to RUN happens on index == DEPTH-1; no wrap is ever observed.

## Test plan
- Reset release, DEPTH = 32 → ready = 0 for 32 cycles, then 1. All reads return 0 and read_busy = 0 throughout.
- RUN: write x5 = 0xDEADBEEF; next cycle read ports 0/1 on x5 → 0xDEADBEEF on both. Write x0 = 0x1234 → x0 still reads 0.
- BYPASS = 1: wEn with x7 = 0xA5A5A5A5 while read_sel0 = 7 → read_data0 = 0xA5A5A5A5 in the same cycle and read_busy0 = 0. BYPASS = 0, same stimulus → old value in that cycle.
- Scoreboard:
  - rsv x3 → read_busy = 1 the next cycle.
  - Write x3 → busy clears.
  - rsv x3 and write x3 in the same cycle → x3 remains busy with the new data stored.
  - rsv x0 → never busy.
- init_req in RUN after writing x9 = 0x55 → ready drops next cycle. After 32 cycles ready = 1, x9 reads 0, and all busy bits = 0. wEn during the sweep has no effect.
- Assert reset at sweep index 10 and at a mid-RUN write → outputs drop to 0 at once. A full 32-cycle sweep follows deassertion; the interrupted write is not visible.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// Register-file bus: decode/writeback side (master) to register file (slave).
interface reg_file_sb_if #(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned REG_SEL_BITS   = 5,
  parameter int unsigned NUM_READ_PORTS = 2
);

  // Sweep control
  logic                                     init_req;
  logic                                     ready;

  // Write / writeback port
  logic                                     wEn;
  logic [REG_SEL_BITS-1:0]                  write_sel;
  logic [REG_DATA_WIDTH-1:0]                write_data;

  // Packed read ports
  logic [NUM_READ_PORTS*REG_SEL_BITS-1:0]   read_sel;
  logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] read_data;
  logic [NUM_READ_PORTS-1:0]                read_busy;

  // Destination reservation
  logic                                     rsv_en;
  logic [REG_SEL_BITS-1:0]                  rsv_sel;

  modport master (
    output init_req, wEn, write_sel, write_data, read_sel, rsv_en, rsv_sel,
    input  ready, read_data, read_busy
  );

  modport slave (
    input  init_req, wEn, write_sel, write_data, read_sel, rsv_en, rsv_sel,
    output ready, read_data, read_busy
  );

endinterface

// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with write bypass, busy scoreboard
// and a self-clearing sweep after reset or on request.
module reg_file_sb #(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned REG_SEL_BITS   = 5,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter bit          BYPASS         = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  reg_file_sb_if.slave bus
);

  localparam int unsigned DW    = REG_DATA_WIDTH;
  localparam int unsigned SB    = REG_SEL_BITS;
  localparam int unsigned NP    = NUM_READ_PORTS;
  localparam int unsigned DEPTH = 32'd1 << REG_SEL_BITS;
  localparam logic [SB-1:0] LAST_IDX = SB'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [SB-1:0]  idx_q, idx_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DW-1:0]  mem_q [DEPTH];

  // Decoded per-cycle actions
  logic sweep_c;
  logic run_c;
  logic init_acc_c;
  logic wr_acc_c;
  logic rsv_acc_c;

  // State, sweep index and scoreboard registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: sweep every index once, then run until a clear is requested
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + SB'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (bus.init_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // FSM outputs: which operations are honoured this cycle
  always_comb begin
    sweep_c    = 1'b0;
    run_c      = 1'b0;
    init_acc_c = 1'b0;
    wr_acc_c   = 1'b0;
    rsv_acc_c  = 1'b0;
    bus.ready  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_c = 1'b1;
      end
      ST_RUN: begin
        run_c      = 1'b1;
        bus.ready  = 1'b1;
        init_acc_c = bus.init_req;
        // A clear request on this edge drops any write/reserve with it
        wr_acc_c   = bus.wEn && (bus.write_sel != '0) && !bus.init_req;
        rsv_acc_c  = bus.rsv_en && (bus.rsv_sel != '0) && !bus.init_req;
      end
      default: begin
        sweep_c = 1'b0;
      end
    endcase
  end

  // Scoreboard: writeback releases, reservation sets; a same-cycle reserve wins
  always_comb begin
    busy_d = busy_q;
    if (init_acc_c) begin
      busy_d = '0;
    end else begin
      if (wr_acc_c) begin
        busy_d[bus.write_sel] = 1'b0;
      end
      if (rsv_acc_c) begin
        busy_d[bus.rsv_sel] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Storage array: sweep zeroes one entry per cycle, otherwise normal writes
  always_ff @(posedge clock) begin
    if (sweep_c) begin
      mem_q[idx_q] <= '0;
    end else if (wr_acc_c) begin
      mem_q[bus.write_sel] <= bus.write_data;
    end
  end

  // Combinational read ports with optional same-cycle forwarding
  always_comb begin
    logic [SB-1:0] sel;
    logic          hit;
    sel           = '0;
    hit           = 1'b0;
    bus.read_data = '0;
    bus.read_busy = '0;
    for (int i = 0; i < int'(NP); i++) begin
      sel = bus.read_sel[i*SB +: SB];
      hit = BYPASS && bus.wEn && (bus.write_sel == sel);
      if (run_c && (sel != '0)) begin
        if (hit) begin
          bus.read_data[i*DW +: DW] = bus.write_data;
        end else begin
          bus.read_data[i*DW +: DW] = mem_q[sel];
        end
        // A forwarded value is final, so it is never reported busy
        bus.read_busy[i] = busy_q[sel] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one bypassing and one non-bypassing instance
// driven with identical stimulus.
module tb_reg_file_sb;

  localparam int unsigned DW    = 32;
  localparam int unsigned SB    = 5;
  localparam int unsigned NP    = 2;
  localparam int unsigned DEPTH = 32;

  logic clock = 1'b0;
  logic reset;

  logic              init_req;
  logic              wen;
  logic [SB-1:0]     wsel;
  logic [DW-1:0]     wdata;
  logic [NP*SB-1:0]  rsel;
  logic              rsv_en;
  logic [SB-1:0]     rsv_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reg_file_sb_if #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SB), .NUM_READ_PORTS(NP)) ifa ();
  reg_file_sb_if #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SB), .NUM_READ_PORTS(NP)) ifb ();

  assign ifa.init_req   = init_req;
  assign ifa.wEn        = wen;
  assign ifa.write_sel  = wsel;
  assign ifa.write_data = wdata;
  assign ifa.read_sel   = rsel;
  assign ifa.rsv_en     = rsv_en;
  assign ifa.rsv_sel    = rsv_sel;

  assign ifb.init_req   = init_req;
  assign ifb.wEn        = wen;
  assign ifb.write_sel  = wsel;
  assign ifb.write_data = wdata;
  assign ifb.read_sel   = rsel;
  assign ifb.rsv_en     = rsv_en;
  assign ifb.rsv_sel    = rsv_sel;

  reg_file_sb #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SB), .NUM_READ_PORTS(NP), .BYPASS(1'b1))
    dut_a (.clock(clock), .reset(reset), .bus(ifa));

  reg_file_sb #(.REG_DATA_WIDTH(DW), .REG_SEL_BITS(SB), .NUM_READ_PORTS(NP), .BYPASS(1'b0))
    dut_b (.clock(clock), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    init_req = 1'b0;
    wen      = 1'b0;
    wsel     = '0;
    wdata    = '0;
    rsv_en   = 1'b0;
    rsv_sel  = '0;
  endtask

  task automatic set_rd(input logic [SB-1:0] p1, input logic [SB-1:0] p0);
    rsel = {p1, p0};
  endtask

  // Counts DEPTH edges of a sweep, checking ready stays low until the last one
  task automatic sweep(input string tag, input int junk_cycles);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < junk_cycles) begin
        wen = 1'b1; wsel = 5'd9; wdata = 32'hFFFF_0000;
        rsv_en = 1'b1; rsv_sel = 5'd9; init_req = 1'b1;
      end else begin
        idle();
      end
      #1;
      chk({tag, "_ready_a"}, 64'(ifa.ready), 64'd0);
      chk({tag, "_ready_b"}, 64'(ifb.ready), 64'd0);
      chk({tag, "_rd_a"}, 64'(ifa.read_data), 64'd0);
      chk({tag, "_busy_a"}, 64'(ifa.read_busy), 64'd0);
      tick();
    end
    idle();
    chk({tag, "_done_ready_a"}, 64'(ifa.ready), 64'd1);
    chk({tag, "_done_ready_b"}, 64'(ifb.ready), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_rd(5'd7, 5'd5);
    wen = 1'b1; wsel = 5'd5; wdata = 32'h1111_1111;
    #1;
    chk("rst_ready_a", 64'(ifa.ready), 64'd0);
    chk("rst_rd_a", 64'(ifa.read_data), 64'd0);
    chk("rst_busy_a", 64'(ifa.read_busy), 64'd0);
    chk("rst_rd_b", 64'(ifb.read_data), 64'd0);
    tick(); tick(); tick();
    chk("rst_hold_ready_a", 64'(ifa.ready), 64'd0);
    idle();
    reset = 1'b1;

    // Power-up sweep with ignored write/reserve/clear traffic
    set_rd(5'd9, 5'd9);
    sweep("init", 30);
    chk("post_init_x9_a", 64'(ifa.read_data[31:0]), 64'd0);
    chk("post_init_busy_a", 64'(ifa.read_busy), 64'd0);

    // Basic write then read on both ports
    set_rd(5'd0, 5'd0);
    wen = 1'b1; wsel = 5'd5; wdata = 32'hDEAD_BEEF;
    tick(); idle();
    set_rd(5'd5, 5'd5);
    #1;
    chk("x5_rd0_a", 64'(ifa.read_data[31:0]), 64'hDEAD_BEEF);
    chk("x5_rd1_a", 64'(ifa.read_data[63:32]), 64'hDEAD_BEEF);
    chk("x5_rd0_b", 64'(ifb.read_data[31:0]), 64'hDEAD_BEEF);

    // x0 is hard-wired to zero
    wen = 1'b1; wsel = 5'd0; wdata = 32'h0000_1234;
    set_rd(5'd0, 5'd0);
    #1;
    chk("x0_bypass_a", 64'(ifa.read_data[31:0]), 64'd0);
    tick(); idle();
    #1;
    chk("x0_rd_a", 64'(ifa.read_data[31:0]), 64'd0);
    chk("x0_rd_b", 64'(ifb.read_data[31:0]), 64'd0);

    // Bypass: reserve x7, then write it while reading it
    rsv_en = 1'b1; rsv_sel = 5'd7;
    tick(); idle();
    set_rd(5'd7, 5'd7);
    #1;
    chk("x7_busy_a", 64'(ifa.read_busy), 64'd3);
    chk("x7_busy_b", 64'(ifb.read_busy), 64'd3);
    wen = 1'b1; wsel = 5'd7; wdata = 32'hA5A5_A5A5;
    #1;
    chk("byp_rd0_a", 64'(ifa.read_data[31:0]), 64'hA5A5_A5A5);
    chk("byp_rd1_a", 64'(ifa.read_data[63:32]), 64'hA5A5_A5A5);
    chk("byp_busy_a", 64'(ifa.read_busy), 64'd0);
    chk("nobyp_rd0_b", 64'(ifb.read_data[31:0]), 64'd0);
    chk("nobyp_busy_b", 64'(ifb.read_busy), 64'd3);
    tick(); idle();
    #1;
    chk("x7_after_a", 64'(ifa.read_data[31:0]), 64'hA5A5_A5A5);
    chk("x7_after_b", 64'(ifb.read_data[31:0]), 64'hA5A5_A5A5);
    chk("x7_free_b", 64'(ifb.read_busy), 64'd0);

    // Scoreboard on x3
    rsv_en = 1'b1; rsv_sel = 5'd3;
    set_rd(5'd0, 5'd3);
    #1;
    chk("x3_pre_busy_a", 64'(ifa.read_busy), 64'd0);
    tick(); idle();
    #1;
    chk("x3_busy_a", 64'(ifa.read_busy), 64'd1);
    wen = 1'b1; wsel = 5'd3; wdata = 32'h0000_0033;
    tick(); idle();
    #1;
    chk("x3_released_a", 64'(ifa.read_busy), 64'd0);
    chk("x3_data_a", 64'(ifa.read_data[31:0]), 64'h33);
    wen = 1'b1; wsel = 5'd3; wdata = 32'h0000_0077;
    rsv_en = 1'b1; rsv_sel = 5'd3;
    #1;
    chk("x3_both_byp_busy_a", 64'(ifa.read_busy), 64'd0);
    tick(); idle();
    #1;
    chk("x3_both_busy_a", 64'(ifa.read_busy), 64'd1);
    chk("x3_both_busy_b", 64'(ifb.read_busy), 64'd1);
    chk("x3_both_data_b", 64'(ifb.read_data[31:0]), 64'h77);
    rsv_en = 1'b1; rsv_sel = 5'd3;
    tick(); idle();
    wen = 1'b1; wsel = 5'd3; wdata = 32'h0000_0099;
    tick(); idle();
    #1;
    chk("x3_no_count_a", 64'(ifa.read_busy), 64'd0);
    rsv_en = 1'b1; rsv_sel = 5'd0;
    tick(); idle();
    set_rd(5'd0, 5'd0);
    #1;
    chk("x0_never_busy_a", 64'(ifa.read_busy), 64'd0);

    // Requested clear; re-reserve x3 so the clear must drop a busy bit
    rsv_en = 1'b1; rsv_sel = 5'd3;
    wen = 1'b1; wsel = 5'd9; wdata = 32'h0000_0055;
    tick(); idle();
    set_rd(5'd3, 5'd9);
    #1;
    chk("x9_rd_a", 64'(ifa.read_data[31:0]), 64'h55);
    chk("x3_busy_pre_clr_a", 64'(ifa.read_busy), 64'd2);
    init_req = 1'b1;
    wen = 1'b1; wsel = 5'd12; wdata = 32'h0000_00AB;
    tick(); idle();
    sweep("req", 31);
    set_rd(5'd3, 5'd9);
    #1;
    chk("clr_x9_a", 64'(ifa.read_data[31:0]), 64'd0);
    chk("clr_x9_b", 64'(ifb.read_data[31:0]), 64'd0);
    chk("clr_busy_a", 64'(ifa.read_busy), 64'd0);
    set_rd(5'd7, 5'd12);
    #1;
    chk("clr_x12_a", 64'(ifa.read_data[31:0]), 64'd0);
    chk("clr_x7_a", 64'(ifa.read_data[63:32]), 64'd0);

    // Reset at sweep index 10 restarts the full sweep
    init_req = 1'b1;
    tick(); idle();
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("midsweep_rst_ready_a", 64'(ifa.ready), 64'd0);
    reset = 1'b1;
    sweep("resweep", 0);

    // Reset during a RUN write
    wen = 1'b1; wsel = 5'd5; wdata = 32'h0000_0011;
    tick(); idle();
    rsv_en = 1'b1; rsv_sel = 5'd5;
    tick(); idle();
    set_rd(5'd0, 5'd5);
    #1;
    chk("x5_11_a", 64'(ifa.read_data[31:0]), 64'h11);
    chk("x5_busy_a", 64'(ifa.read_busy), 64'd1);
    wen = 1'b1; wsel = 5'd5; wdata = 32'h0000_0022;
    #1;
    chk("x5_22_byp_a", 64'(ifa.read_data[31:0]), 64'h22);
    chk("x5_11_b", 64'(ifb.read_data[31:0]), 64'h11);
    reset = 1'b0;
    #1;
    chk("runrst_ready_a", 64'(ifa.ready), 64'd0);
    chk("runrst_rd_a", 64'(ifa.read_data), 64'd0);
    chk("runrst_busy_b", 64'(ifb.read_busy), 64'd0);
    tick(); tick();
    idle();
    reset = 1'b1;
    sweep("runrst", 0);
    #1;
    chk("runrst_x5_a", 64'(ifa.read_data[31:0]), 64'd0);
    chk("runrst_x5_b", 64'(ifb.read_data[31:0]), 64'd0);
    chk("runrst_x5_busy_a", 64'(ifa.read_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
